// File: rtl/pcp_issue_ctrl.sv
// PCPI-to-coprocessor issue controller: decodes M-extension ops, issues one request, returns result.
// Latency: pcpi_valid -> cp_valid 1 cycle; cp_ready -> pcpi_ready 1 cycle; ISSUE aborts after TIMEOUT_CYCLES.
// Backpressure: pcpi_wait stalls the core while a request is outstanding; one request at a time, no queueing.
module pcp_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pcpi_valid,
    input  logic [31:0]      pcpi_insn,
    input  logic [31:0]      pcpi_rs1,
    input  logic [31:0]      pcpi_rs2,
    output logic             pcpi_wr,
    output logic [31:0]      pcpi_rd,
    output logic             pcpi_wait,
    output logic             pcpi_ready,
    output logic             cp_valid,
    output logic [31:0]      cp_instruction,
    output logic [31:0]      cp_rs1,
    output logic [31:0]      cp_rs2,
    input  logic             cp_ready,
    input  logic             cp_busy,
    input  logic [31:0]      cp_rd,
    output logic             timeout_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_RESP  = 3'd2,
        S_ABORT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] to_cnt;
    logic          insn_match;
    logic          issue_accept;
    logic          timeout_hit;

    // cp_busy is informational only; the FSM never waits on it.
    logic          unused_busy;
    assign unused_busy = cp_busy;

    // M-extension: OP opcode with funct7 = 0000001, any funct3.
    assign insn_match   = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    assign issue_accept = (state == S_IDLE) && pcpi_valid && insn_match;
    // A zero timeout parameter disables the abort path entirely.
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs; a response beats a timeout in the same cycle.
    always_comb begin
        state_nxt   = state;
        cp_valid    = 1'b0;
        pcpi_wait   = 1'b0;
        pcpi_ready  = 1'b0;
        pcpi_wr     = 1'b0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue_accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cp_valid  = 1'b1;
                pcpi_wait = 1'b1;
                if (cp_ready) begin
                    state_nxt = S_RESP;
                end else if (timeout_hit) begin
                    state_nxt = S_ABORT;
                end
            end
            S_RESP: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                state_nxt  = S_DONE;
            end
            S_ABORT: begin
                timeout_err = 1'b1;
                state_nxt   = S_DONE;
            end
            S_DONE: begin
                // Hold here until the core drops valid so the same instruction is not reissued.
                if (!pcpi_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, result capture, timeout counting and completion count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cp_instruction <= '0;
            cp_rs1         <= '0;
            cp_rs2         <= '0;
            pcpi_rd        <= '0;
            to_cnt         <= '0;
            op_count       <= '0;
        end else begin
            if (issue_accept) begin
                cp_instruction <= pcpi_insn;
                cp_rs1         <= pcpi_rs1;
                cp_rs2         <= pcpi_rs2;
            end
            if ((state == S_ISSUE) && cp_ready) begin
                pcpi_rd <= cp_rd;
            end
            to_cnt <= (state == S_ISSUE) ? to_cnt + 1'b1 : '0;
            if (state == S_RESP) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
